mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle CPU's memory interface: accepts one word read/write request at a time and answers after a programmable number of wait states.
- Holds a word-organised storage array with byte-enable writes.
- Flags misaligned and out-of-range accesses.
- Replaces the zero-latency instruction and data memories when the CPU is moved to a request/response memory bus.

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Request/response bus between the CPU memory port and the responder.
//   Request side : req_valid, req_we, req_addr (byte address), req_wdata,
//                  req_be (per-byte write enables), answered by req_ready.
//   Response side: rsp_valid (one-cycle pulse), rsp_rdata, rsp_err.
//   Modports: master = requester (CPU side), slave = responder.
// ---------------------------------------------------------------------------
interface mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Word-organised memory that accepts one read/write request at a time and
//   answers after WAIT_CYCLES wait states. Writes merge bytes under req_be.
//   Misaligned or out-of-range addresses answer with rsp_err=1, rdata=0 and
//   never touch the array.
//   Ports:
//     clk   - clock, all state changes on the rising edge
//     reset - synchronous, active-high
//     bus   - mem_responder_if.slave (request / response handshake)
//   Parameters:
//     ADDR_WIDTH  - word-address bits, depth = 2**ADDR_WIDTH words
//     WAIT_CYCLES - wait states between acceptance and response (0..15)
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;

  // Request captured at acceptance
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    err_q;

  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  // Storage; zero at power-up, never cleared by reset
  logic [31:0]             mem_q [DEPTH] = '{default: 32'd0};

  logic                    req_ready;
  logic                    accept;
  logic                    enter_resp;
  logic                    live_err;
  logic [ADDR_WIDTH-1:0]   live_idx;

  logic                    op_we;
  logic [ADDR_WIDTH-1:0]   op_idx;
  logic [31:0]             op_wdata;
  logic [3:0]              op_be;
  logic                    op_err;
  logic [31:0]             rd_word;
  logic [31:0]             merged;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = bus.req_valid && req_ready;

  // Anything above the array or not word-aligned is an error
  assign live_err = (bus.req_addr[1:0] != 2'b00) ||
                    ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign live_idx = bus.req_addr[ADDR_WIDTH+1:2];

  // With zero wait states the edge that accepts is also the edge that
  // enters RESP, so the live request must be used instead of the latched one.
  assign op_we    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign op_idx   = (state_q == IDLE) ? live_idx      : idx_q;
  assign op_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign op_be    = (state_q == IDLE) ? bus.req_be    : be_q;
  assign op_err   = (state_q == IDLE) ? live_err      : err_q;

  assign rd_word  = mem_q[op_idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = op_be[gi] ? op_wdata[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_resp  = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          // A reset on this edge aborts: no commit, no response
          enter_resp = !reset;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Response registers load only on entry to RESP and read zero otherwise,
    // so they clear themselves on the way out of RESP.
    if (enter_resp) begin
      rsp_err_d   = op_err;
      rsp_rdata_d = op_err ? 32'd0 : (op_we ? merged : rd_word);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      err_q       <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        idx_q   <= live_idx;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
        err_q   <= live_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && op_we && !op_err) begin
      mem_q[op_idx] <= merged;
    end
  end

  // Reset masks the outputs immediately, cutting a RESP pulse short
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RESP) && !reset;
  assign bus.rsp_rdata = reset ? 32'd0 : rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q && !reset;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Randomised and directed bench for mem_responder with a word-array
//   reference model. A second instance with zero wait states checks the
//   minimum-latency path.
// ---------------------------------------------------------------------------
module tb_mem_responder;
  localparam int AW    = 10;
  localparam int WC    = 2;
  localparam int WORDS = 2 ** AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ref_mem [WORDS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte address must be word aligned and fall inside the array
  task automatic ref_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] exp_d, output logic exp_e);
    int idx;
    if ((a % 4) != 0 || a >= 32'(4 * WORDS)) begin
      exp_d = 32'd0;
      exp_e = 1'b1;
    end else begin
      idx = int'(a / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
      exp_d = ref_mem[idx];
      exp_e = 1'b0;
    end
  endtask

  // Present a request, wait for it to be accepted, then scribble the inputs
  task automatic start_req(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) bus.req_valid = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    start_req(tag, we, a, wd, be);
    ref_access(we, a, wd, be, exp_d, exp_e);
    check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    wait_rsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(WC));
    check({tag, "_rdata"}, bus.rsp_rdata, exp_d);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
    $display("txn %s we=%0d addr=%08h wdata=%08h be=%h -> rdata=%08h err=%0d lat=%0d",
             tag, we, a, wd, be, bus.rsp_rdata, bus.rsp_err, lat);
    tick();
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_pulse_end"}, {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          acc_cyc[$];
    logic [31:0] exp_q[$];
    int          pulses;
    int          busy;
    logic        saw;
    logic [31:0] a;
    logic [31:0] hold_addr [3];

    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
    bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = 32'd0;
    bus.req_wdata  = 32'd0; bus.req_be = 4'd0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0;
    bus0.req_wdata = 32'd0; bus0.req_be = 4'd0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Zero-wait-state instance: response right after the accepting edge
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h4;
    bus0.req_wdata = 32'h12345678; bus0.req_be = 4'hF;
    check("w0_ready", 32'(bus0.req_ready), 32'd1);
    tick();
    bus0.req_valid = 1'b0;
    check("w0_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    check("w0_rsp_rdata", bus0.rsp_rdata, 32'h12345678);
    check("w0_busy", 32'(bus0.req_ready), 32'd0);
    tick();
    check("w0_ready_again", 32'(bus0.req_ready), 32'd1);
    check("w0_pulse_end", 32'(bus0.rsp_valid), 32'd0);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 32'h4;
    tick();
    bus0.req_valid = 1'b0;
    check("r0_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    check("r0_rsp_rdata", bus0.rsp_rdata, 32'h12345678);
    tick();
    check("r0_ready_again", 32'(bus0.req_ready), 32'd1);
    $display("txn zero_wait write/read 0x4 done");

    // Directed sequence
    do_txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_txn("rd10", 1'b0, 32'h10, 32'h0, 4'h0);
    do_txn("wr10_be5", 1'b1, 32'h10, 32'h11223344, 4'b0101);
    do_txn("rd10_b", 1'b0, 32'h10, 32'h0, 4'h0);
    do_txn("wr10_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    do_txn("wr00", 1'b1, 32'h0, 32'h55AA55AA, 4'hF);
    do_txn("rd_mis", 1'b0, 32'h12, 32'h0, 4'h0);
    do_txn("wr_oor", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    do_txn("wr_mis", 1'b1, 32'h3, 32'hFFFFFFFF, 4'hF);
    do_txn("rd00", 1'b0, 32'h0, 32'h0, 4'h0);
    do_txn("rd_top", 1'b0, 32'hFFC, 32'h0, 4'h0);

    // req_valid held high across three reads
    hold_addr[0] = 32'h10; hold_addr[1] = 32'h0; hold_addr[2] = 32'h14;
    pulses = 0; busy = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = hold_addr[0];
    for (int cyc = 0; cyc < 40 && pulses < 3; cyc++) begin
      if (bus.rsp_valid) begin
        pulses++;
        if (exp_q.size() > 0) check("hold_rdata", bus.rsp_rdata, exp_q.pop_front());
        else check("hold_extra_pulse", 32'(pulses), 32'(acc_cyc.size()));
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(ref_mem[hold_addr[acc_cyc.size()-1] / 4]);
      end else if (bus.req_valid) begin
        busy++;
      end
      tick();
      if (acc_cyc.size() >= 3) bus.req_valid = 1'b0;
      else bus.req_addr = hold_addr[acc_cyc.size()];
    end
    bus.req_valid = 1'b0;
    check("hold_accepts", 32'(acc_cyc.size()), 32'd3);
    check("hold_pulses", 32'(pulses), 32'd3);
    check("hold_busy_cycles", 32'(busy), 32'(2 * (WC + 1)));
    if (acc_cyc.size() == 3) begin
      check("hold_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(WC + 2));
      check("hold_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(WC + 2));
    end
    $display("txn hold_valid accepts=%0d pulses=%0d", acc_cyc.size(), pulses);
    tick();

    // Reset while in WAIT: write is dropped, no response
    start_req("rst_wait", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    tick();
    reset = 1'b1;
    #1;
    check("rst_wait_ready", 32'(bus.req_ready), 32'd0);
    check("rst_wait_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_wait_ready_after", 32'(bus.req_ready), 32'd1);
    saw = 1'b0;
    repeat (4) begin
      if (bus.rsp_valid) saw = 1'b1;
      tick();
    end
    check("rst_wait_no_rsp", 32'(saw), 32'd0);
    $display("txn rst_wait write 0x20 aborted");
    do_txn("rd20_dropped", 1'b0, 32'h20, 32'h0, 4'h0);

    // Reset while in RESP: write already committed, pulse cut short
    start_req("rst_resp", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    ref_mem[32'h20 / 4] = 32'hCAFEF00D;
    wait_rsp(lat);
    check("rst_resp_latency", 32'(lat), 32'(WC));
    reset = 1'b1;
    #1;
    check("rst_resp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_resp_rdata", bus.rsp_rdata, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_resp_ready_after", 32'(bus.req_ready), 32'd1);
    $display("txn rst_resp write 0x20 committed");
    do_txn("rd20_kept", 1'b0, 32'h20, 32'h0, 4'h0);

    // Randomised traffic over a small window so reads hit earlier writes
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0: a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(1, 3));
        1: begin
          a = $urandom;
          if (a < 32'(4 * WORDS)) a = a | 32'h8000_0000;
        end
        2: a = 32'(4 * (WORDS - 1 - $urandom_range(0, 3)));
        default: a = 32'(4 * $urandom_range(0, 15));
      endcase
      do_txn($sformatf("rnd%0d", t), 1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
